prog_sequence_generator: RTL and testbench

Programmable successor to the team's fixed 8-step pattern generator. Emits a user-loaded table of DATA_W-bit words on a valid/ready stream and supports three modes: loop, one-shot and ping-pong. Table contents, sequence length and mode are runtime-configurable. Sits between register-mapped control logic and any downstream stream consumer, such as a DAC feeder or test-pattern injector.

---
 rtl/prog_sequence_generator_if.sv | 12 +
 rtl/prog_sequence_generator.sv | 117 +++++++++++
 tb/tb_prog_sequence_generator.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/prog_sequence_generator_if.sv
// prog_sequence_generator_if: valid/ready stream that carries a sequence word and its table index
interface prog_sequence_generator_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] index;
    modport master (output valid, data, index, input ready);
    modport slave  (input valid, data, index, output ready);
endinterface

// File: rtl/prog_sequence_generator.sv
// prog_sequence_generator: streams a loadable word table in loop, one-shot or ping-pong order
module prog_sequence_generator #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_wr_en,
    input  logic [ADDR_W-1:0]         i_wr_addr,
    input  logic [DATA_W-1:0]         i_wr_data,
    input  logic [ADDR_W-1:0]         i_last_idx,
    input  logic [1:0]                i_mode,
    input  logic                      i_start,
    input  logic                      i_stop,
    prog_sequence_generator_if.master o_stream,
    output logic                      o_busy,
    output logic                      o_done
);
    typedef enum logic {S_IDLE, S_RUN} state_t;
    localparam logic [ADDR_W-1:0] LAST_MAX = ADDR_W'(DEPTH - 1);
    state_t            r_state, w_next_state;
    logic [DATA_W-1:0] r_table [DEPTH];
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_index, r_last, w_next_idx;
    logic [1:0]        r_mode;
    logic              r_dir_down, w_next_dir_down, r_done;
    logic              w_xfer, w_restart, w_step, w_finish;
    logic              w_oneshot, w_pingpong, w_at_last;

    assign w_xfer     = (r_state == S_RUN) & o_stream.ready;
    assign w_oneshot  = r_mode == 2'b01;
    assign w_pingpong = r_mode == 2'b10;
    assign w_at_last  = r_index == r_last;

    // successor index; one-shot shares the loop rule since its end is handled by the FSM
    always_comb begin
        w_next_dir_down = r_dir_down;
        w_next_idx      = w_at_last ? '0 : r_index + 1'b1;
        if (w_pingpong) begin
            if (r_last == '0) begin
                w_next_idx = '0;
            end else if (!r_dir_down) begin
                w_next_idx      = w_at_last ? r_last - 1'b1 : r_index + 1'b1;
                w_next_dir_down = w_at_last;
            end else begin
                w_next_idx      = (r_index == '0) ? ADDR_W'(1) : r_index - 1'b1;
                w_next_dir_down = r_index != '0;
            end
        end
    end

    // control decisions in priority order: stop, start, end of one-shot, plain transfer
    always_comb begin
        w_next_state = r_state;
        w_restart    = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        if (r_state == S_RUN && i_stop) begin
            w_next_state = S_IDLE;
        end else if (i_start) begin
            w_next_state = S_RUN;
            w_restart    = 1'b1;
        end else if (w_xfer && w_oneshot && w_at_last) begin
            w_next_state = S_IDLE;
            w_finish     = 1'b1;
        end else if (w_xfer) begin
            w_step = 1'b1;
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // pattern table; loads below read the value from before a same-cycle write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
        end else if (i_wr_en && 32'(i_wr_addr) < DEPTH) begin
            r_table[i_wr_addr] <= i_wr_data;
        end
    end

    // output word, index, direction and latched run configuration
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data     <= '0;
            r_index    <= '0;
            r_last     <= '0;
            r_mode     <= '0;
            r_dir_down <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_restart) begin
                r_mode     <= i_mode;
                r_last     <= (i_last_idx > LAST_MAX) ? LAST_MAX : i_last_idx;
                r_index    <= '0;
                r_data     <= r_table[0];
                r_dir_down <= 1'b0;
            end else if (w_step) begin
                r_index    <= w_next_idx;
                r_data     <= r_table[w_next_idx];
                r_dir_down <= w_next_dir_down;
            end
        end
    end

    assign o_stream.valid = r_state == S_RUN;
    assign o_stream.data  = r_data;
    assign o_stream.index = r_index;
    assign o_busy         = r_state == S_RUN;
    assign o_done         = r_done;
endmodule

// File: tb/tb_prog_sequence_generator.sv
// tb_prog_sequence_generator: directed checks of loop, one-shot, ping-pong, backpressure and control edge cases
module tb_prog_sequence_generator;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [2:0] last_idx = '0;
    logic [1:0] mode = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       busy, done;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] tbl [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
    int         pp  [10] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3};

    always #5 clk = ~clk;

    prog_sequence_generator_if #(.DATA_W(8), .ADDR_W(3)) s_if ();

    prog_sequence_generator #(.DATA_W(8), .DEPTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_last_idx (last_idx),
        .i_mode     (mode),
        .i_start    (start),
        .i_stop     (stop),
        .o_stream   (s_if),
        .o_busy     (busy),
        .o_done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic out(input string tag, input logic v, input logic [7:0] d, input logic [2:0] i);
        chk({tag, "_valid"}, 32'(s_if.valid), 32'(v));
        chk({tag, "_data"}, 32'(s_if.data), 32'(d));
        chk({tag, "_index"}, 32'(s_if.index), 32'(i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_if.ready = 1'b0;
        #2;
        out("reset", 1'b0, 8'h00, 3'd0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = tbl[i];
            step();
        end
        wr_en = 1'b0;
        chk("idle_valid", 32'(s_if.valid), 0);
        // loop, L=7
        mode = 2'b00; last_idx = 3'd7; start = 1'b1; s_if.ready = 1'b1;
        step();
        start = 1'b0;
        out("loop_first", 1'b1, 8'hAF, 3'd0);
        chk("loop_busy", 32'(busy), 1);
        for (int k = 1; k < 10; k++) begin
            step();
            out("loop", 1'b1, tbl[k % 8], 3'(k % 8));
            chk("loop_done", 32'(done), 0);
        end
        // one-shot, L=3, started over a running loop
        mode = 2'b01; last_idx = 3'd3; start = 1'b1;
        step();
        start = 1'b0;
        out("os_first", 1'b1, 8'hAF, 3'd0);
        chk("os_restart_done", 32'(done), 0);
        for (int k = 1; k < 4; k++) begin
            step();
            out("os", 1'b1, tbl[k], 3'(k));
        end
        step();
        out("os_end", 1'b0, 8'h78, 3'd3);
        chk("os_end_busy", 32'(busy), 0);
        chk("os_end_done", 32'(done), 1);
        step();
        chk("os_done_clear", 32'(done), 0);
        chk("os_idle_valid", 32'(s_if.valid), 0);
        // ping-pong, L=3
        mode = 2'b10; last_idx = 3'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            out("pp", 1'b1, tbl[pp[k]], 3'(pp[k]));
        end
        // stop beats start
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        out("stopstart", 1'b0, 8'h78, 3'd3);
        chk("stopstart_busy", 32'(busy), 0);
        chk("stopstart_done", 32'(done), 0);
        // L=0 loop re-emits word 0
        mode = 2'b00; last_idx = 3'd0; start = 1'b1;
        step();
        start = 1'b0;
        out("l0_loop_a", 1'b1, 8'hAF, 3'd0);
        step();
        out("l0_loop_b", 1'b1, 8'hAF, 3'd0);
        // L=0 one-shot emits one word then done
        mode = 2'b01; start = 1'b1;
        step();
        start = 1'b0;
        out("l0_os", 1'b1, 8'hAF, 3'd0);
        step();
        chk("l0_os_valid", 32'(s_if.valid), 0);
        chk("l0_os_done", 32'(done), 1);
        // backpressure: ready 1,0,0,1,1
        mode = 2'b00; last_idx = 3'd7; start = 1'b1;
        step();
        start = 1'b0;
        out("bp0", 1'b1, 8'hAF, 3'd0);
        step();
        out("bp1", 1'b1, 8'hBC, 3'd1);
        s_if.ready = 1'b0;
        step();
        out("bp2", 1'b1, 8'hBC, 3'd1);
        step();
        out("bp3", 1'b1, 8'hBC, 3'd1);
        s_if.ready = 1'b1;
        step();
        out("bp4", 1'b1, 8'hE2, 3'd2);
        // restart from index 5
        step(); step(); step();
        out("pre_restart", 1'b1, 8'hE2, 3'd5);
        start = 1'b1;
        step();
        start = 1'b0;
        out("restart", 1'b1, 8'hAF, 3'd0);
        // table write while running; mode/last changes must be ignored
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h55; mode = 2'b01; last_idx = 3'd1;
        step();
        wr_en = 1'b0;
        out("wr_a", 1'b1, 8'hBC, 3'd1);
        step();
        out("wr_new", 1'b1, 8'h55, 3'd2);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h66;
        step();
        wr_en = 1'b0;
        out("wr_prewrite", 1'b1, 8'h78, 3'd3);
        for (int k = 0; k < 8; k++) step();
        out("wr_next_pass", 1'b1, 8'h66, 3'd3);
        chk("wr_busy", 32'(busy), 1);
        chk("wr_done", 32'(done), 0);
        // asynchronous reset mid-stream at index 4
        step();
        chk("pre_reset_index", 32'(s_if.index), 4);
        reset_n = 1'b0;
        #1;
        out("async_reset", 1'b0, 8'h00, 3'd0);
        chk("async_reset_busy", 32'(busy), 0);
        step();
        reset_n = 1'b1; mode = 2'b00; last_idx = 3'd7; start = 1'b1;
        step();
        start = 1'b0;
        out("cleared0", 1'b1, 8'h00, 3'd0);
        step();
        out("cleared1", 1'b1, 8'h00, 3'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
